// File: rtl/spi_ram_master.sv
// spi_ram_master
//   Host-side SPI master for the SPI slave/RAM subsystem. Accepts one request
//   at a time over a valid/ready handshake and sequences it as two command
//   frames (address, then data). Reads add a turnaround window and an
//   ADDR_SIZE-bit capture of MISO, after which the byte is returned on a
//   one-cycle response strobe. One MOSI bit per clk cycle, no divided SCLK.
//
// Parameters
//   ADDR_SIZE : address/data width; frame length is ADDR_SIZE+3 bits
//   READ_TA   : idle cycles between the read-data command bits and the first
//               MISO sample (0 allowed)
//
// Ports
//   clk, rst_n                 : clock, asynchronous active-low reset
//   req_valid/req_ready        : request handshake (ready only in IDLE)
//   req_wr/req_addr/req_wdata  : request fields, captured at acceptance
//   rsp_valid/rsp_rdata        : one-cycle read strobe, data held until the
//                                next read completes
//   busy                       : transaction in progress (~req_ready)
//   SS_n, MOSI, MISO           : SPI pins
module spi_ram_master #(
  parameter int ADDR_SIZE = 8,
  parameter int READ_TA   = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_wr,
  input  logic [ADDR_SIZE-1:0] req_addr,
  input  logic [ADDR_SIZE-1:0] req_wdata,
  output logic                 rsp_valid,
  output logic [ADDR_SIZE-1:0] rsp_rdata,
  output logic                 busy,
  output logic                 SS_n,
  output logic                 MOSI,
  input  logic                 MISO
);

  localparam int F       = ADDR_SIZE + 3;
  localparam int CNT_MAX = (F > READ_TA) ? F : READ_TA;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] CNT_FRAME = CNT_W'(F - 1);
  localparam logic [CNT_W-1:0] CNT_TURN  = CNT_W'((READ_TA > 0) ? READ_TA - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_CAP   = CNT_W'(ADDR_SIZE - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT1,
    S_GAP,
    S_SHIFT2,
    S_TURN,
    S_CAPTURE
  } state_t;

  state_t                 state, state_nxt;
  logic [CNT_W-1:0]       cnt, cnt_nxt;
  logic                   cnt_zero;
  logic                   accept;
  logic                   done;

  logic                   wr_q;
  logic [ADDR_SIZE-1:0]   wdata_q;
  logic [F-1:0]           tx_q;
  logic [ADDR_SIZE-1:0]   rx_q;

  assign cnt_zero = (cnt == '0);
  assign accept   = req_valid && (state == S_IDLE);

  // Next-state / counter logic. The counter always holds the number of
  // remaining cycles in the current state minus one.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        if (req_valid) begin
          state_nxt = S_SHIFT1;
          cnt_nxt   = CNT_FRAME;
        end
      end
      S_SHIFT1: begin
        if (cnt_zero) state_nxt = S_GAP;
        else          cnt_nxt   = cnt - CNT_ONE;
      end
      S_GAP: begin
        state_nxt = S_SHIFT2;
        cnt_nxt   = CNT_FRAME;
      end
      S_SHIFT2: begin
        if (cnt_zero) begin
          if (wr_q) begin
            state_nxt = S_IDLE;
          end else if (READ_TA == 0) begin
            state_nxt = S_CAPTURE;
            cnt_nxt   = CNT_CAP;
          end else begin
            state_nxt = S_TURN;
            cnt_nxt   = CNT_TURN;
          end
        end else begin
          cnt_nxt = cnt - CNT_ONE;
        end
      end
      S_TURN: begin
        if (cnt_zero) begin
          state_nxt = S_CAPTURE;
          cnt_nxt   = CNT_CAP;
        end else begin
          cnt_nxt = cnt - CNT_ONE;
        end
      end
      S_CAPTURE: begin
        if (cnt_zero) begin
          state_nxt = S_IDLE;
          done      = 1'b1;
        end else begin
          cnt_nxt = cnt - CNT_ONE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Control state: FSM, counter and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      rsp_valid <= done;
      // The final MISO bit is sampled on the same edge that leaves CAPTURE.
      if (done) rsp_rdata <= {rx_q[ADDR_SIZE-2:0], MISO};
    end
  end

  // Datapath: request capture, transmit shifter, receive shifter. These are
  // never observed outside the states that load them, so they carry no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      wr_q    <= req_wr;
      wdata_q <= req_wdata;
      // Leading bit duplicates cmd[1]; cmd = {~wr, 0} for the address frame.
      tx_q    <= {~req_wr, ~req_wr, 1'b0, req_addr};
    end else if (state == S_GAP) begin
      tx_q <= {~wr_q, ~wr_q, 1'b1, (wr_q ? wdata_q : {ADDR_SIZE{1'b0}})};
    end else if ((state == S_SHIFT1) || (state == S_SHIFT2)) begin
      tx_q <= {tx_q[F-2:0], 1'b0};
    end
    if (state == S_CAPTURE) rx_q <= {rx_q[ADDR_SIZE-2:0], MISO};
  end

  // Outputs decode directly from registered state so SS_n rises as soon as
  // reset is asserted and MOSI only moves after a rising edge.
  assign req_ready = (state == S_IDLE);
  assign busy      = ~req_ready;
  assign SS_n      = (state == S_IDLE) || (state == S_GAP);
  assign MOSI      = ((state == S_SHIFT1) || (state == S_SHIFT2)) && tx_q[F-1];

endmodule

// File: tb/tb_spi_ram_master.sv
module tb_spi_ram_master;

  localparam int AS     = 8;
  localparam int TA     = 2;
  localparam int F      = AS + 3;
  localparam int LAT_WR = 2*F + 2;
  localparam int LAT_RD = 2*F + 2 + TA + AS;
  localparam int DEPTH  = 1 << AS;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic          req_wr;
  logic [AS-1:0] req_addr;
  logic [AS-1:0] req_wdata;
  logic          rsp_valid;
  logic [AS-1:0] rsp_rdata;
  logic          busy;
  logic          SS_n;
  logic          MOSI;
  logic          MISO = 1'b0;

  always #5 clk = ~clk;

  spi_ram_master #(.ADDR_SIZE(AS), .READ_TA(TA)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_wr    (req_wr),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .busy      (busy),
    .SS_n      (SS_n),
    .MOSI      (MOSI),
    .MISO      (MISO)
  );

  typedef struct {
    logic [F-1:0] bits;
    int           len;
  } frame_t;

  typedef struct {
    logic [AS-1:0] data;
    time           t0;
  } rsp_t;

  frame_t        exp_frames[$];
  rsp_t          exp_rsp[$];
  logic [AS-1:0] ref_mem [DEPTH];
  logic [AS-1:0] slv_mem [DEPTH];

  int  n_checks = 0;
  int  n_fail   = 0;
  int  resets_req = 0;
  bit  prev_keep = 1'b0;
  time prev_done_t = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Cycle number (relative to acceptance edge t0) of the current negedge.
  function automatic int cyc_of(input time t0);
    return int'(($time - t0 - 5) / 10) + 1;
  endfunction

  // ---------------- Slave + RAM behavioural model / frame monitor ---------
  int           s_idx = 0;
  logic [F-1:0] s_fr  = '0;
  logic [AS-1:0] slv_addr = '0;
  int           resets_seen = 0;

  always @(negedge clk) begin
    if (SS_n === 1'b0) begin
      if (s_idx < F) s_fr = {s_fr[F-2:0], MOSI};
      MISO = 1'b0;
      if (s_idx >= F + TA && s_idx < F + TA + AS && s_fr[F-2 -: 2] == 2'b11)
        MISO = slv_mem[slv_addr][AS-1-(s_idx-F-TA)];
      s_idx++;
    end else begin
      MISO = 1'b0;
      if (s_idx > 0) begin
        if (resets_seen != resets_req) begin
          resets_seen = resets_req;
        end else begin
          if (exp_frames.size() == 0) begin
            check("unexpected_frame", s_fr, '1);
            n_checks = n_checks;
          end else begin
            frame_t e;
            e = exp_frames.pop_front();
            check("frame_bits", s_fr, e.bits);
            check("frame_len", s_idx, e.len);
          end
          case (s_fr[F-2 -: 2])
            2'b00, 2'b10: slv_addr = s_fr[AS-1:0];
            2'b01:        slv_mem[slv_addr] = s_fr[AS-1:0];
            default: ;
          endcase
        end
        s_idx = 0;
      end
    end
  end

  // ---------------- Response monitor ----------------
  logic [AS-1:0] last_rdata = '0;
  bit            chk_hold = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      last_rdata = '0;
      chk_hold   = 1'b0;
    end else begin
      if (chk_hold) begin
        check("rdata_hold", rsp_rdata, last_rdata);
        check("rsp_pulse_width", rsp_valid, 1'b0);
        chk_hold = 1'b0;
      end
      if (rsp_valid) begin
        if (exp_rsp.size() == 0) begin
          check("unexpected_rsp", rsp_valid, 1'b0);
        end else begin
          rsp_t r;
          r = exp_rsp.pop_front();
          check("rsp_rdata", rsp_rdata, r.data);
          check("rsp_latency", cyc_of(r.t0), LAT_RD);
          last_rdata = r.data;
          chk_hold   = 1'b1;
        end
      end
    end
  end

  // ---------------- Stimulus ----------------
  task automatic push_expect(input logic wr, input logic [AS-1:0] a,
                             input logic [AS-1:0] d, input time t0);
    frame_t f;
    rsp_t   r;
    if (wr) begin
      f.bits = {3'b000, a};        f.len = F;          exp_frames.push_back(f);
      f.bits = {3'b001, d};        f.len = F;          exp_frames.push_back(f);
      ref_mem[a] = d;
    end else begin
      f.bits = {3'b110, a};        f.len = F;          exp_frames.push_back(f);
      f.bits = {3'b111, {AS{1'b0}}}; f.len = F + TA + AS; exp_frames.push_back(f);
      r.data = ref_mem[a];
      r.t0   = t0;
      exp_rsp.push_back(r);
    end
  endtask

  // Called mid-cycle (after a negedge). Returns at the negedge where the DUT
  // is idle again.
  task automatic issue(input logic wr, input logic [AS-1:0] a,
                       input logic [AS-1:0] d, input bit keep);
    int  w;
    time t0;
    req_wr = wr; req_addr = a; req_wdata = d; req_valid = 1'b1;
    w = 0;
    while (!req_ready && w < 200) begin @(negedge clk); w++; end
    if (!req_ready) begin
      check("accept_timeout", req_ready, 1'b1);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    t0 = $time;
    push_expect(wr, a, d, t0);
    if (prev_keep) check("b2b_accept_gap", int'(t0 - prev_done_t), 5);
    #1;
    req_wr = 1'($urandom); req_addr = AS'($urandom); req_wdata = AS'($urandom);
    if (!keep) req_valid = 1'b0;
    w = 0;
    do begin @(negedge clk); w++; end while (!req_ready && w < 200);
    check("done_ready", req_ready, 1'b1);
    check(wr ? "wr_latency" : "rd_latency", cyc_of(t0), wr ? LAT_WR : LAT_RD);
    check("done_ss_n_high", SS_n, 1'b1);
    prev_done_t = $time;
    prev_keep   = keep;
  endtask

  task automatic reset_mid_read(input logic [AS-1:0] a);
    frame_t f;
    int w;
    req_wr = 1'b0; req_addr = a; req_wdata = '0; req_valid = 1'b1;
    w = 0;
    while (!req_ready && w < 200) begin @(negedge clk); w++; end
    @(posedge clk);
    f.bits = {3'b110, a}; f.len = F; exp_frames.push_back(f);
    #1 req_valid = 1'b0;
    repeat (28) @(negedge clk);
    resets_req++;
    rst_n = 1'b0;
    #1;
    check("rst_mid_ss_n", SS_n, 1'b1);
    check("rst_mid_rsp_valid", rsp_valid, 1'b0);
    check("rst_mid_rsp_rdata", rsp_rdata, '0);
    check("rst_mid_mosi", MOSI, 1'b0);
    check("rst_mid_ready", req_ready, 1'b1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    prev_keep = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      ref_mem[i] = '0;
      slv_mem[i] = '0;
    end
    rst_n = 1'b0; req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_wdata = '0;
    #2;
    check("rst_ss_n", SS_n, 1'b1);
    check("rst_mosi", MOSI, 1'b0);
    check("rst_ready", req_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_rdata", rsp_rdata, '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed: write then read of the same location.
    issue(1'b1, 8'h3C, 8'hA5, 1'b0);
    issue(1'b0, 8'h3C, 8'h00, 1'b0);

    // Back-to-back with req_valid held; inputs scrambled while busy.
    issue(1'b1, 8'h55, 8'h3C, 1'b1);
    issue(1'b0, 8'h55, 8'h00, 1'b0);

    // Address/data extremes.
    issue(1'b1, 8'h00, 8'hFF, 1'b0);
    issue(1'b1, 8'hFF, 8'h00, 1'b0);
    issue(1'b0, 8'h00, 8'h00, 1'b1);
    issue(1'b0, 8'hFF, 8'h00, 1'b0);

    // Reset in the middle of the capture window, then a normal read.
    reset_mid_read(8'h3C);
    @(negedge clk);
    issue(1'b0, 8'h3C, 8'h00, 1'b0);

    // Randomized traffic over a small address set to get read-after-write hits.
    for (int i = 0; i < 40; i++) begin
      logic          wr;
      logic [AS-1:0] a;
      logic [AS-1:0] d;
      bit            keep;
      wr   = 1'($urandom_range(0, 1));
      a    = ($urandom_range(0, 3) == 0) ? AS'($urandom) : AS'($urandom_range(0, 7));
      d    = AS'($urandom);
      keep = (i < 39) ? bit'($urandom_range(0, 1)) : 1'b0;
      issue(wr, a, d, keep);
      if (!keep) repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    repeat (5) @(negedge clk);
    check("frames_drained", exp_frames.size(), 0);
    check("rsp_drained", exp_rsp.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
